// File: rtl/sysbus_responder.sv
// Purpose : single-outstanding register-bank responder on a valid/ready command/response bus.
// Latency : response valid exactly WAIT_CYC+1 cycles after the command is accepted.
// Backpressure: rsp_valid/rdata/error are held until rsp_ready; cmd_ready stays low until the response is taken.
//
// Ports:
//   clk, rst               - single clock, synchronous active-high reset
//   cmd_valid/cmd_ready    - command handshake; cmd_addr/we/wem/wdata sampled only on accept
//   rsp_valid/rsp_ready    - response handshake; rsp_rdata/rsp_error are zero when rsp_valid is low
//
// Word 0 is a read-only ID word; words 1..DEPTH-1 are byte-writable RAM cleared by reset.
module sysbus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          DEPTH     = 16,
  parameter int          WAIT_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_wem,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
  localparam logic [31:0] ID_WORD = 32'h5350_0001;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic [31:0]   off;
  logic          hit;
  logic [AW-1:0] idx;
  logic          accept;

  // Ready comes from registered state only; rst masks it so no command is
  // ever offered as accepted during a reset cycle.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Wrapping subtraction makes addresses below the base land far above SPAN.
  assign off = cmd_addr - BASE_ADDR;
  assign hit = (off[1:0] == 2'b00) && (off < SPAN);
  assign idx = off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_d   = mem_q;
    // Word 0 is a constant; keeping it in the array lets reads use one mux.
    mem_d[0] = ID_WORD;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end
          error_d = !hit;
          rdata_d = (hit && !cmd_we) ? mem_q[idx] : 32'h0;
          if (hit && cmd_we && (idx != '0)) begin
            for (int b = 0; b < 4; b++) begin
              if (cmd_wem[b]) begin
                mem_d[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
              end
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        rdata_d = 32'h0;
        error_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == 0) ? ID_WORD : 32'h0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      mem_q   <= mem_d;
    end
  end

  // The response register is loaded at accept, so it must be masked while
  // the transaction is still waiting out its wait states.
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_error = rsp_valid ? error_q : 1'b0;

endmodule

// File: tb/tb_sysbus_responder.sv
module tb_sysbus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;          // 0 = default instance, 1 = WAIT_CYC=0 instance
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic        cmd_we;
  logic [3:0]  cmd_wem;
  logic [31:0] cmd_wdata;
  logic        rsp_ready;

  logic        cmd_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  logic        a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_rsp_error;
  logic [31:0] a_rsp_rdata;
  logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_cmd_valid = cmd_valid && !sel;
  assign a_rsp_ready = rsp_ready && !sel;
  assign b_cmd_valid = cmd_valid && sel;
  assign b_rsp_ready = rsp_ready && sel;

  assign cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign rsp_error = sel ? b_rsp_error : a_rsp_error;

  sysbus_responder u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (a_cmd_valid),
    .cmd_ready (a_cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_wem   (cmd_wem),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_error (a_rsp_error)
  );

  sysbus_responder #(.WAIT_CYC(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (b_cmd_valid),
    .cmd_ready (b_cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_wem   (cmd_wem),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_error (b_rsp_error)
  );

  // Drives one full transaction from posedge+1 and returns at posedge+1 after
  // the response handshake. lat counts cycles from the accept edge to the
  // first cycle rsp_valid is seen; -1 means no response within the budget.
  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [3:0] wem,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic err, output int lat);
    int n = 0;
    cmd_we = we; cmd_addr = addr; cmd_wem = wem; cmd_wdata = wdata; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wdata = 32'h0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata;
    err = rsp_error;
    if (rsp_valid !== 1'b1) lat = -1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_a got %b want 0", a_cmd_ready); end
    checks++; if (b_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_b got %b want 0", b_cmd_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'h0 || a_rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_data got %h/%b want 0/0", a_rsp_rdata, a_rsp_error); end
    rst = 1'b0;
    #1;
    checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", a_cmd_ready); end
    @(posedge clk); #1;
    checks++; if (a_cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b%b want 11", a_cmd_ready, b_cmd_ready); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int lat;
    sel = 1'b0;
    do_cmd(1'b1, 32'h2004, 4'hF, 32'hDEAD_BEEF, rd, err, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL wr_rsp got %h/%b want 0/0", rd, err); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL idle_outputs got %b/%h want 0/0", rsp_valid, rsp_rdata); end
    do_cmd(1'b0, 32'h2004, 4'h0, 32'h0, rd, err, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++; $display("FAIL rd_word1 got %h/%b want deadbeef/0", rd, err); end
    do_cmd(1'b0, 32'h2000, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'h5350_0001 || err !== 1'b0) begin errors++; $display("FAIL rd_id got %h/%b want 53500001/0", rd, err); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic err; int lat;
    sel = 1'b0;
    do_cmd(1'b1, 32'h2008, 4'b0101, 32'h1122_3344, rd, err, lat);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lane_wr_err got %b want 0", err); end
    do_cmd(1'b0, 32'h2008, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'h0022_0044) begin errors++; $display("FAIL lane_rd got %h want 00220044", rd); end
    do_cmd(1'b1, 32'h2008, 4'h0, 32'hFFFF_FFFF, rd, err, lat);
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wem0_rsp got %h/%b want 0/0", rd, err); end
    do_cmd(1'b0, 32'h2008, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'h0022_0044) begin errors++; $display("FAIL wem0_unchanged got %h want 00220044", rd); end
    do_cmd(1'b1, 32'h203C, 4'hF, 32'hCAFE_F00D, rd, err, lat);
    do_cmd(1'b0, 32'h203C, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'hCAFE_F00D || err !== 1'b0) begin errors++; $display("FAIL last_word got %h/%b want cafef00d/0", rd, err); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat;
    sel = 1'b0;
    do_cmd(1'b0, 32'h2040, 4'h0, 32'h0, rd, err, lat);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range got %h/%b want 0/1", rd, err); end
    do_cmd(1'b0, 32'h2002, 4'h0, 32'h0, rd, err, lat);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_misalign got %h/%b want 0/1", rd, err); end
    do_cmd(1'b0, 32'h1FFC, 4'h0, 32'h0, rd, err, lat);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_below got %h/%b want 0/1", rd, err); end
    checks++; if (lat != 2) begin errors++; $display("FAIL err_latency got %0d want 2", lat); end
    do_cmd(1'b1, 32'h2006, 4'hF, 32'h1234_5678, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wr_misalign got %b want 1", err); end
    do_cmd(1'b0, 32'h2004, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_no_change got %h want deadbeef", rd); end
  endtask

  task automatic test_backpressure();
    sel = 1'b0; rsp_ready = 1'b0;
    cmd_we = 1'b0; cmd_addr = 32'h2004; cmd_wem = 4'h0; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Second command held from here; it must not be sampled until the bus frees.
    cmd_addr = 32'h2008;
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_wait got rdy %b vld %b want 0 0", cmd_ready, rsp_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got vld %b data %h rdy %b want 1 deadbeef 0", i, rsp_valid, rsp_rdata, cmd_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release got vld %b rdy %b want 0 1", rsp_valid, cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got rdy %b want 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0022_0044) begin errors++; $display("FAIL bp_second_rsp got %b/%h want 1/00220044", rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_wait0();
    logic [31:0] rd; logic err; int lat;
    sel = 1'b1;
    do_cmd(1'b0, 32'h2000, 4'h0, 32'h0, rd, err, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL w0_latency got %0d want 1", lat); end
    checks++; if (rd !== 32'h5350_0001 || err !== 1'b0) begin errors++; $display("FAIL w0_id got %h/%b want 53500001/0", rd, err); end
    do_cmd(1'b1, 32'h2000, 4'hF, 32'hFFFF_FFFF, rd, err, lat);
    checks++; if (err !== 1'b0 || lat != 1) begin errors++; $display("FAIL w0_wr_id got err %b lat %0d want 0 1", err, lat); end
    do_cmd(1'b0, 32'h2000, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'h5350_0001) begin errors++; $display("FAIL w0_id_ro got %h want 53500001", rd); end
    sel = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic err; int lat;
    logic seen;
    sel = 1'b0;
    cmd_we = 1'b0; cmd_addr = 32'h2004; cmd_wem = 4'h0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_in_reset got rdy %b vld %b want 0 0", cmd_ready, rsp_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rw_ready_after got %b want 1", cmd_ready); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rw_dropped got rsp_valid 1 want 0"); end
    do_cmd(1'b0, 32'h2004, 4'h0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'h0 || err !== 1'b0 || lat != 2) begin errors++; $display("FAIL rw_word1_clear got %h/%b lat %0d want 0/0 2", rd, err, lat); end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_we = 1'b0;
    cmd_wem = 4'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_wait0();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
